// File: rtl/device_eth_replay_if.sv
// AXI-Stream Ethernet RX bundle produced by the frame replayer.
// Handshake: a beat transfers on a clock edge where tvalid && tready are both high;
// once tvalid is raised the master holds tvalid, tdata, tkeep, tlast and tuser
// unchanged until that transfer happens. tready may toggle freely.
interface device_eth_replay_if #(
  parameter int C_DATA_WIDTH = 64
) ();
  localparam int KEEP_WIDTH = C_DATA_WIDTH / 8;

  logic                    tvalid;
  logic                    tready;
  logic [C_DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0]   tkeep;
  logic                    tlast;
  logic                    tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/device_eth_replay.sv
// Ethernet RX frame replayer: plays a preloaded beat memory onto an AXI-Stream
// with a start delay, inter-frame gaps, a loop count and optional tuser error
// injection on one frame per pass. Honours tready backpressure.
module device_eth_replay #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int MEM_DEPTH    = 256,
  parameter int AW           = $clog2(MEM_DEPTH),
  parameter int START_DELAY  = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int NUM_LOOPS    = 1,
  parameter int BYTE_SWAP    = 1
) (
  input  logic                    eth_clk,
  input  logic                    sys_rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [C_DATA_WIDTH-1:0] wr_data,
  input  logic [KEEP_WIDTH-1:0]   wr_keep,
  input  logic                    wr_last,
  input  logic [AW:0]             num_beats,
  input  logic                    start,
  input  logic                    inj_err_en,
  input  logic [15:0]             inj_err_frame,
  device_eth_replay_if.master     eth_rx,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             frame_count,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_SEND, S_GAP, S_FIN} state_t;

  localparam logic [31:0] C_DLY_LAST = 32'(START_DELAY - 1);
  localparam logic [31:0] C_GAP_LAST = 32'(GAP_CYCLES - 1);

  state_t                  r_state;
  logic [C_DATA_WIDTH-1:0] r_mem_data [MEM_DEPTH];
  logic [KEEP_WIDTH-1:0]   r_mem_keep [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]    r_mem_last;
  logic [AW-1:0]           r_rd_addr;
  logic [AW:0]             r_num_beats;
  logic [31:0]             r_cnt;
  logic [31:0]             r_pass;
  logic [15:0]             r_frame_idx;
  logic [15:0]             r_frame_count;
  logic                    r_inj_en;
  logic [15:0]             r_inj_frame;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;

  logic [C_DATA_WIDTH-1:0] w_rd_data;
  logic [KEEP_WIDTH-1:0]   w_rd_keep;
  logic [C_DATA_WIDTH-1:0] w_out_data;
  logic [KEEP_WIDTH-1:0]   w_out_keep;
  logic                    w_final;
  logic                    w_last;
  logic                    w_xfer;
  logic [31:0]             w_pass_next;
  logic                    w_loops_done;

  assign w_rd_data    = r_mem_data[r_rd_addr];
  assign w_rd_keep    = r_mem_keep[r_rd_addr];
  // The entry at num_beats-1 always closes a frame, whatever was loaded.
  assign w_final      = ({1'b0, r_rd_addr} == (r_num_beats - 1'b1));
  assign w_last       = r_mem_last[r_rd_addr] | w_final;
  assign w_xfer       = r_valid & eth_rx.tready;
  assign w_pass_next  = r_pass + 32'd1;
  assign w_loops_done = (NUM_LOOPS != 0) && (w_pass_next == 32'(NUM_LOOPS));

  // Beat memory load; writes are dropped while a replay is in progress.
  always_ff @(posedge eth_clk) begin
    if (wr_en && !r_busy) begin
      r_mem_data[wr_addr] <= wr_data;
      r_mem_keep[wr_addr] <= wr_keep;
      r_mem_last[wr_addr] <= wr_last;
    end
  end

  // Optional byte reversal of data and bit reversal of keep on the way out.
  always_comb begin
    w_out_data = '0;
    w_out_keep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (BYTE_SWAP != 0) begin
        w_out_data[8*i +: 8] = w_rd_data[8*(KEEP_WIDTH-1-i) +: 8];
        w_out_keep[i]        = w_rd_keep[KEEP_WIDTH-1-i];
      end else begin
        w_out_data[8*i +: 8] = w_rd_data[8*i +: 8];
        w_out_keep[i]        = w_rd_keep[i];
      end
    end
  end

  // Replay sequencer: IDLE -> DELAY -> SEND <-> GAP ... -> FIN -> IDLE.
  always_ff @(posedge eth_clk) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_rd_addr     <= '0;
      r_num_beats   <= '0;
      r_cnt         <= '0;
      r_pass        <= '0;
      r_frame_idx   <= '0;
      r_frame_count <= '0;
      r_inj_en      <= 1'b0;
      r_inj_frame   <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (num_beats != '0)) begin
            r_num_beats   <= num_beats;
            r_inj_en      <= inj_err_en;
            r_inj_frame   <= inj_err_frame;
            r_rd_addr     <= '0;
            r_pass        <= '0;
            r_frame_idx   <= '0;
            r_frame_count <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b1;
            if (START_DELAY == 0) begin
              r_state <= S_SEND;
              r_valid <= 1'b1;
            end else begin
              r_state <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt == C_DLY_LAST) begin
            r_cnt   <= '0;
            r_state <= S_SEND;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (w_last) begin
              r_frame_count <= r_frame_count + 16'd1;
              if (w_final) begin
                r_pass <= w_pass_next;
                r_rd_addr   <= '0;
                r_frame_idx <= '0;
              end else begin
                r_rd_addr   <= r_rd_addr + 1'b1;
                r_frame_idx <= r_frame_idx + 16'd1;
              end
              if (w_final && w_loops_done) begin
                r_state <= S_FIN;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end else if (GAP_CYCLES != 0) begin
                r_state <= S_GAP;
                r_valid <= 1'b0;
                r_cnt   <= '0;
              end
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_SEND;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign eth_rx.tvalid = r_valid;
  assign eth_rx.tdata  = r_valid ? w_out_data : '0;
  assign eth_rx.tkeep  = r_valid ? w_out_keep : '0;
  assign eth_rx.tlast  = r_valid & w_last;
  assign eth_rx.tuser  = r_valid & w_last & r_inj_en & (r_frame_idx == r_inj_frame);
  assign busy          = r_busy;
  assign done          = r_done;
  assign frame_count   = r_frame_count;
  assign dbg_state     = r_state;

endmodule
